// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word lines and per-set round-robin replacement.
// Lines refill word 0 upward, one memctrl transaction per word; clear and invalidate act mid-refill.
module icache_sa #(
  parameter int INDEX_WIDTH  = 3,
  parameter int WAY_WIDTH    = 1,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        to_icache,
  input  logic [31:0] pc,
  input  logic        clear,
  input  logic        invalidate,
  output logic        have_result,
  output logic [31:0] inst,
  output logic        icache_to_memctrl,
  output logic [31:0] address,
  input  logic        received,
  input  logic        memctrl_to_icache,
  input  logic [31:0] inst_in
);
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WAYS  = 1 << WAY_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WW    = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;
  localparam int OW    = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;
  localparam int MA    = WAY_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                   state_reg;
  logic                     valid_reg [WAYS][SETS];
  logic [TAG_W-1:0]         tag_arr   [WAYS][SETS];
  logic [WW-1:0]            ptr_reg   [SETS];
  logic [31:0]              data_mem  [1 << MA];
  logic [INDEX_WIDTH-1:0]   set_reg;
  logic [TAG_W-1:0]         tag_reg;
  logic [OW-1:0]            off_reg;
  logic [OW-1:0]            k_reg;
  logic [WW-1:0]            victim_reg;
  logic [31:0]              addr_reg;
  logic [31:0]              inst_reg;
  logic [31:0]              crit_reg;
  logic [31:0]              rd_data_reg;
  logic                     req_reg;
  logic                     hr_reg;
  logic                     src_ram_reg;
  logic                     cancelled_reg;
  logic                     discard_reg;

  logic [29:0]              pc_word;
  logic                     unused_pc_bits;
  logic [OW-1:0]            off_in;
  logic [INDEX_WIDTH-1:0]   set_in;
  logic [TAG_W-1:0]         tag_in;
  logic [31:0]              line_base;
  logic [WAYS-1:0]          hit_vec;
  logic [WW-1:0]            hit_way;
  logic                     hit;
  logic                     accept;
  logic                     data_event;
  logic                     last_word;
  logic [WW-1:0]            ptr_next;

  function automatic logic [MA-1:0] mem_addr(input logic [WW-1:0] way,
                                             input logic [INDEX_WIDTH-1:0] set,
                                             input logic [OW-1:0] word);
    return (MA'(way) << (INDEX_WIDTH + OFFSET_WIDTH)) | (MA'(set) << OFFSET_WIDTH) | MA'(word);
  endfunction

  assign pc_word        = pc[31:2];
  assign unused_pc_bits = ^pc[1:0];
  assign off_in         = OW'(pc_word & 30'(WORDS - 1));
  assign set_in         = INDEX_WIDTH'(pc_word >> OFFSET_WIDTH);
  assign tag_in         = TAG_W'(pc_word >> (OFFSET_WIDTH + INDEX_WIDTH));
  assign line_base      = {pc_word & ~30'(WORDS - 1), 2'b00};

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi] = valid_reg[gi][set_in] && (tag_arr[gi][set_in] == tag_in);
    end
  endgenerate

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WW'(w);
    end
  end

  assign hit        = |hit_vec;
  // A delivery cycle never overlaps a new lookup, so the pulse stays one cycle wide.
  assign accept     = rdy && (state_reg == IDLE) && to_icache && !clear && !invalidate && !hr_reg;
  assign data_event = rdy && memctrl_to_icache &&
                      ((state_reg == WAIT) || ((state_reg == REQ) && received));
  assign last_word  = (k_reg == OW'(WORDS - 1));
  assign ptr_next   = (WAYS == 1) ? '0 : ptr_reg[set_reg] + WW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      set_reg       <= '0;
      tag_reg       <= '0;
      off_reg       <= '0;
      k_reg         <= '0;
      victim_reg    <= '0;
      addr_reg      <= '0;
      inst_reg      <= '0;
      crit_reg      <= '0;
      req_reg       <= 1'b0;
      hr_reg        <= 1'b0;
      src_ram_reg   <= 1'b0;
      cancelled_reg <= 1'b0;
      discard_reg   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_reg[w][s] <= 1'b0;
      end
    end else if (rdy) begin
      hr_reg <= 1'b0;
      if (invalidate) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid_reg[w][s] <= 1'b0;
      end
      if (state_reg != IDLE) begin
        if (clear) cancelled_reg <= 1'b1;
        if (invalidate) discard_reg <= 1'b1;
      end
      if (accept && hit) begin
        hr_reg      <= 1'b1;
        src_ram_reg <= 1'b1;
      end else if (accept) begin
        set_reg    <= set_in;
        tag_reg    <= tag_in;
        off_reg    <= off_in;
        victim_reg <= ptr_reg[set_in];
        k_reg      <= '0;
        addr_reg   <= line_base;
        req_reg    <= 1'b1;
        state_reg  <= REQ;
      end else if (data_event) begin
        if (k_reg == off_reg) crit_reg <= inst_in;
        if (last_word) begin
          // The line is installed even when cancelled; only a pending invalidate discards it.
          if (!(discard_reg || invalidate)) valid_reg[victim_reg][set_reg] <= 1'b1;
          ptr_reg[set_reg] <= ptr_next;
          if (!(cancelled_reg || clear)) begin
            inst_reg    <= (k_reg == off_reg) ? inst_in : crit_reg;
            src_ram_reg <= 1'b0;
            hr_reg      <= 1'b1;
          end
          req_reg       <= 1'b0;
          cancelled_reg <= 1'b0;
          discard_reg   <= 1'b0;
          state_reg     <= IDLE;
        end else begin
          k_reg     <= k_reg + OW'(1);
          addr_reg  <= addr_reg + 32'd4;
          req_reg   <= 1'b1;
          state_reg <= REQ;
        end
      end else if ((state_reg == REQ) && received) begin
        req_reg   <= 1'b0;
        state_reg <= WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !rst) begin
      if (data_event) begin
        data_mem[mem_addr(victim_reg, set_reg, k_reg)] <= inst_in;
        if (last_word) tag_arr[victim_reg][set_reg] <= tag_reg;
      end
      if (accept) rd_data_reg <= data_mem[mem_addr(hit_way, set_in, off_in)];
    end
  end

  assign have_result       = hr_reg;
  assign inst              = src_ram_reg ? rd_data_reg : inst_reg;
  assign icache_to_memctrl = req_reg;
  assign address           = addr_reg;
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: default 2-way/4-word instance plus a direct-mapped one-word instance
// behind a shared memctrl responder that returns address ^ 0xC0DE0000.
module tb_icache_sa;
  logic clk = 1'b0;
  logic rst, rdy, clear, invalidate, received, mcd;
  logic to_a, to_b;
  logic [31:0] pc, inst_in;
  logic hr_a, hr_b, req_a, req_b;
  logic [31:0] inst_a, inst_b, addr_a, addr_b;
  logic sel_dm;
  logic hr_s, req_s;
  logic [31:0] inst_s, addr_s;

  int vectors = 0;
  int miscompares = 0;
  int lat_recv = 1;
  int lat_data = 2;
  bit same_cycle = 0;
  logic [31:0] req_log[$];

  always #5 clk = ~clk;

  icache_sa dut_a (
    .clk(clk), .rst(rst), .rdy(rdy), .to_icache(to_a), .pc(pc), .clear(clear),
    .invalidate(invalidate), .have_result(hr_a), .inst(inst_a), .icache_to_memctrl(req_a),
    .address(addr_a), .received(received), .memctrl_to_icache(mcd), .inst_in(inst_in)
  );

  icache_sa #(.INDEX_WIDTH(3), .WAY_WIDTH(0), .OFFSET_WIDTH(0)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy), .to_icache(to_b), .pc(pc), .clear(clear),
    .invalidate(invalidate), .have_result(hr_b), .inst(inst_b), .icache_to_memctrl(req_b),
    .address(addr_b), .received(received), .memctrl_to_icache(mcd), .inst_in(inst_in)
  );

  assign hr_s   = sel_dm ? hr_b : hr_a;
  assign req_s  = sel_dm ? req_b : req_a;
  assign inst_s = sel_dm ? inst_b : inst_a;
  assign addr_s = sel_dm ? addr_b : addr_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memctrl model: shares rdy, acts just after each falling edge
  initial begin
    int phase = 0;
    int cnt = 0;
    logic [31:0] addr_l = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        phase = 0; received = 0; mcd = 0;
      end else if (rdy) begin
        received = 0; mcd = 0;
        case (phase)
          0: if (req_s) begin
            addr_l = addr_s; req_log.push_back(addr_l); cnt = lat_recv; phase = 1;
          end
          1: if (cnt == 0) begin
            received = 1;
            if (same_cycle) begin
              mcd = 1; inst_in = mem_word(addr_l); phase = 3;
            end else begin
              cnt = lat_data; phase = 2;
            end
          end else cnt--;
          2: if (cnt == 0) begin
            mcd = 1; inst_in = mem_word(addr_l); phase = 3;
          end else cnt--;
          default: phase = 0;
        endcase
      end
    end
  end

  // act: 0 none, 1 clear mid-refill, 2 invalidate mid-refill, 3 rdy low 5 cycles in WAIT, 4 rst mid-refill
  task automatic fetch(input string name, input bit dm, input logic [31:0] a, input int act,
                       input bit exp_hit, input bit exp_hr, input logic [31:0] exp_inst);
    int n0, cyc, limit, words;
    bit got, fired;
    logic [31:0] snap;
    words = dm ? 1 : 4;
    n0 = req_log.size();
    got = 0; fired = 0;
    limit = exp_hr ? 300 : 80;
    @(negedge clk);
    pc = a;
    if (dm) to_b = 1; else to_a = 1;
    @(negedge clk);
    to_a = 0; to_b = 0;
    cyc = 1;
    while (cyc <= limit) begin
      clear = 0; invalidate = 0;
      if (hr_s) begin got = 1; break; end
      if (act != 0 && !fired && (req_log.size() - n0 >= 2) && (act != 3 || !req_s)) begin
        fired = 1;
        if (act == 1) clear = 1;
        else if (act == 2) invalidate = 1;
        else if (act == 3) begin
          snap = addr_s;
          rdy = 0;
          repeat (5) begin
            @(negedge clk); cyc++;
            check({name, "_hold_addr"}, addr_s, snap);
            check({name, "_hold_req"}, 32'(req_s), 32'd0);
            check({name, "_hold_hr"}, 32'(hr_s), 32'd0);
          end
          rdy = 1;
        end else begin
          rst = 1;
          @(negedge clk);
          check({name, "_rst_hr"}, 32'(hr_s), 32'd0);
          check({name, "_rst_req"}, 32'(req_s), 32'd0);
          check({name, "_rst_addr"}, addr_s, 32'd0);
          check({name, "_rst_inst"}, inst_s, 32'd0);
          rst = 0;
          break;
        end
      end
      @(negedge clk); cyc++;
    end
    clear = 0; invalidate = 0;
    if (act != 4) begin
      check({name, "_hr"}, 32'(got), 32'(exp_hr));
      if (got) begin
        check({name, "_inst"}, inst_s, exp_inst);
        check({name, "_hit"}, 32'(cyc == 1), 32'(exp_hit));
        @(negedge clk);
        check({name, "_pulse"}, 32'(hr_s), 32'd0);
        check({name, "_reqs"}, 32'(req_log.size() - n0), exp_hit ? 32'd0 : 32'(words));
        if (!exp_hit && req_log.size() > n0)
          check({name, "_addr"}, req_log[n0], a & ~32'(words * 4 - 1));
      end else begin
        check({name, "_reqs"}, 32'(req_log.size() - n0), 32'(words));
      end
    end
  endtask

  initial begin
    rst = 1; rdy = 1; clear = 0; invalidate = 0; to_a = 0; to_b = 0;
    pc = '0; received = 0; mcd = 0; inst_in = '0; sel_dm = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_hr", 32'(hr_a), 32'd0);
    check("reset_req", 32'(req_a), 32'd0);
    check("reset_addr", addr_a, 32'd0);
    check("reset_inst", inst_a, 32'd0);

    fetch("cold100", 0, 32'h100, 0, 0, 1, 32'hC0DE_0100);
    for (int i = 0; i < 4; i++)
      check($sformatf("cold_addr%0d", i), req_log[i], 32'h100 + 32'(4 * i));
    fetch("hit108", 0, 32'h108, 0, 1, 1, 32'hC0DE_0108);

    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    fetch("a000", 0, 32'h000, 0, 0, 1, 32'hC0DE_0000);
    same_cycle = 1;
    fetch("a080", 0, 32'h080, 0, 0, 1, 32'hC0DE_0080);
    same_cycle = 0;
    fetch("a000_hit", 0, 32'h004, 0, 1, 1, 32'hC0DE_0004);
    fetch("a080_hit", 0, 32'h08C, 0, 1, 1, 32'hC0DE_008C);
    fetch("a100_evict", 0, 32'h100, 0, 0, 1, 32'hC0DE_0100);
    fetch("a080_keep", 0, 32'h080, 0, 1, 1, 32'hC0DE_0080);
    fetch("a000_gone", 0, 32'h000, 0, 0, 1, 32'hC0DE_0000);

    fetch("clr200", 0, 32'h200, 1, 0, 0, 32'h0);
    fetch("hit204", 0, 32'h204, 0, 1, 1, 32'hC0DE_0204);

    fetch("inv100", 0, 32'h100, 0, 0, 1, 32'hC0DE_0100);
    fetch("hit10c", 0, 32'h10C, 0, 1, 1, 32'hC0DE_010C);
    @(negedge clk); invalidate = 1;
    @(negedge clk); invalidate = 0;
    fetch("inv100_miss", 0, 32'h100, 0, 0, 1, 32'hC0DE_0100);
    fetch("invmid300", 0, 32'h308, 2, 0, 1, 32'hC0DE_0308);
    fetch("inv300_miss", 0, 32'h308, 0, 0, 1, 32'hC0DE_0308);

    fetch("rdy400", 0, 32'h404, 3, 0, 1, 32'hC0DE_0404);
    fetch("rst500", 0, 32'h500, 4, 0, 0, 32'h0);
    fetch("rst500_miss", 0, 32'h500, 0, 0, 1, 32'hC0DE_0500);

    @(negedge clk); sel_dm = 1;
    fetch("dm40", 1, 32'h040, 0, 0, 1, 32'hC0DE_0040);
    fetch("dm40_hit", 1, 32'h040, 0, 1, 1, 32'hC0DE_0040);
    fetch("dm60", 1, 32'h060, 0, 0, 1, 32'hC0DE_0060);
    fetch("dm40_again", 1, 32'h040, 0, 0, 1, 32'hC0DE_0040);
    fetch("dm44", 1, 32'h044, 0, 0, 1, 32'hC0DE_0044);
    fetch("dm44_hit", 1, 32'h044, 0, 1, 1, 32'hC0DE_0044);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
